// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: parses a length-prefixed little-endian byte stream
// and emits one registered 32-bit write per assembled word.
module instr_mem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   asm_q, asm_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          xfer;
  logic          last_word;
  logic [15:0]   hdr_count;

  assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign busy      = in_ready;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

  assign xfer      = in_valid && in_ready;
  assign hdr_count = {in_data, count_q[7:0]};
  // waddr_q already points at the word being completed, so it doubles as the word counter.
  assign last_word = ((16'(waddr_q) + 16'd1) == count_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // Advance after each pulse, except the final one so waddr never wraps at count==DEPTH.
    if (we_q && (state_q != S_DONE)) begin
      waddr_d = waddr_q + AW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          count_d = 16'd0;
          lane_d  = 2'd0;
          waddr_d = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          count_d[7:0] = in_data;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          count_d = hdr_count;
          lane_d  = 2'd0;
          if (hdr_count == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr_count} > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {in_data, asm_q};
              if (last_word) begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= 16'd0;
      lane_q  <= 2'd0;
      asm_q   <= 24'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader: a byte-count based reference
// model is compared every cycle, plus fixed-stream literal checks.
module tb_instr_mem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase is derived from bytes accepted since the last start.
  typedef enum int {PH_IDLE, PH_BUSY, PH_DONE, PH_ERR} ph_t;

  bit          m_valid = 0;
  bit          m_armed;
  int          m_n;
  int          m_cnt;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_waddr_zero;
  logic [7:0]  m_data [0:4*DEPTH-1];

  function automatic ph_t m_phase();
    if (!m_armed)                 return PH_IDLE;
    if (m_n < 2)                  return PH_BUSY;
    if (m_cnt == 0)               return PH_DONE;
    if (m_cnt > DEPTH)            return PH_ERR;
    if (m_n < 2 + 4 * m_cnt)      return PH_BUSY;
    return PH_DONE;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_armed = 0; m_n = 0; m_cnt = 0;
      m_we = 0; m_waddr = 0; m_wdata = 32'd0; m_waddr_zero = 1;
    end else if (m_valid) begin
      ph_t ph;
      ph = m_phase();
      m_we = 0;
      if (ph != PH_BUSY) begin
        if (start) begin
          m_armed = 1; m_n = 0; m_cnt = 0; m_waddr_zero = 1;
        end
      end else if (in_valid) begin
        if (m_n == 0) m_cnt = int'(in_data);
        else if (m_n == 1) m_cnt = m_cnt + 256 * int'(in_data);
        else begin
          int d;
          d = m_n - 2;
          m_data[d] = in_data;
          if (d % 4 == 3) begin
            int k;
            k = d / 4;
            m_we = 1;
            m_waddr = k;
            m_wdata = {m_data[4*k+3], m_data[4*k+2], m_data[4*k+1], m_data[4*k]};
            m_waddr_zero = 0;
          end
        end
        m_n++;
      end
    end
  end

  // Log of DUT writes for the literal scenario checks.
  int wlog_addr[$];
  logic [31:0] wlog_data[$];
  bit wlog_done[$];

  always @(negedge clk) begin
    if (m_valid) begin
      ph_t ph;
      ph = m_phase();
      check("cyc_in_ready", {31'd0, in_ready}, {31'd0, ph == PH_BUSY});
      check("cyc_busy",     {31'd0, busy},     {31'd0, ph == PH_BUSY});
      check("cyc_done",     {31'd0, done},     {31'd0, ph == PH_DONE});
      check("cyc_err",      {31'd0, err},      {31'd0, ph == PH_ERR});
      check("cyc_we",       {31'd0, we},       {31'd0, m_we});
      check("cyc_wdata",    wdata,             m_wdata);
      if (m_we) check("cyc_waddr", 32'(waddr), 32'(m_waddr));
      else if (m_waddr_zero) check("cyc_waddr_zero", 32'(waddr), 32'd0);
      if (we === 1'b1) begin
        wlog_addr.push_back(int'(waddr));
        wlog_data.push_back(wdata);
        wlog_done.push_back(done);
      end
    end
  end

  logic [7:0] stream[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wlog_addr.delete(); wlog_data.delete(); wlog_done.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: continuous, 1: in_valid toggled every other cycle, 2: random gaps.
  task automatic send(input int mode, input bit poke_start);
    for (int i = 0; i < stream.size(); i++) begin
      int waited;
      if (mode == 1 && i > 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); tick();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_data = 8'($urandom); tick();
        end
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      if (poke_start && i == 3) start = 1'b1;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 40) begin
        tick(); start = 1'b0; waited++;
      end
      if (waited >= 40) begin
        check("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic mk_basic();
    stream.delete();
    stream.push_back(8'h02); stream.push_back(8'h00);
    stream.push_back(8'h93); stream.push_back(8'h00); stream.push_back(8'h70); stream.push_back(8'h00);
    stream.push_back(8'h13); stream.push_back(8'h01); stream.push_back(8'h10); stream.push_back(8'h00);
  endtask

  task automatic check_basic_log(input string tag);
    check({tag, "_nwrites"}, 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() >= 2) begin
      check({tag, "_addr0"}, 32'(wlog_addr[0]), 32'd0);
      check({tag, "_data0"}, wlog_data[0], 32'h00700093);
      check({tag, "_addr1"}, 32'(wlog_addr[1]), 32'd1);
      check({tag, "_data1"}, wlog_data[1], 32'h00100113);
      check({tag, "_done_with_last_we"}, {31'd0, wlog_done[1]}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fb [0:4*DEPTH-1];
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",       {31'd0, we},       32'd0);
    check("rst_waddr",    32'(waddr),        32'd0);
    check("rst_wdata",    wdata,             32'd0);
    check("rst_flags",    {29'd0, busy, done, err}, 32'd0);

    // Basic load, then junk bytes in DONE must be ignored.
    clear_log(); do_start(); mk_basic(); send(0, 0);
    #1;
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_we",   {31'd0, we},   32'd1);
    tick();
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    in_valid = 1'b1;
    repeat (3) begin in_data = 8'($urandom); tick(); end
    in_valid = 1'b0;
    #1;
    check_basic_log("basic");

    // Empty load.
    clear_log(); do_start();
    stream.delete(); stream.push_back(8'h00); stream.push_back(8'h00);
    send(0, 0);
    #1;
    check("empty_done",     {31'd0, done},     32'd1);
    check("empty_in_ready", {31'd0, in_ready}, 32'd0);
    check("empty_nwrites",  32'(wlog_addr.size()), 32'd0);

    // Oversize header, then recovery.
    clear_log(); do_start();
    stream.delete(); stream.push_back(8'h01); stream.push_back(8'h01);
    send(0, 0);
    #1;
    check("over_err",      {31'd0, err},      32'd1);
    check("over_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_data = 8'hAA; tick(); tick(); in_valid = 1'b0;
    #1;
    check("over_nwrites",  32'(wlog_addr.size()), 32'd0);
    do_start();
    #1;
    check("over_err_cleared", {31'd0, err}, 32'd0);
    mk_basic(); send(0, 0);
    #1;
    check_basic_log("over_reload");

    // Throttled input.
    clear_log(); do_start(); mk_basic(); send(1, 0);
    #1;
    check_basic_log("throttle");

    // Reset mid-load after two data bytes of word 0.
    clear_log(); do_start();
    mk_basic(); while (stream.size() > 4) void'(stream.pop_back());
    send(0, 0);
    do_reset();
    #1;
    check("midrst_outputs", {25'd0, in_ready, we, busy, done, err, |waddr, |wdata}, 32'd0);
    check("midrst_nwrites", 32'(wlog_addr.size()), 32'd0);
    do_start(); mk_basic(); send(0, 0);
    #1;
    check_basic_log("midrst_reload");

    // Full-depth load.
    clear_log(); do_start();
    stream.delete(); stream.push_back(8'h00); stream.push_back(8'h01);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      fb[i] = 8'($urandom);
      stream.push_back(fb[i]);
    end
    send(0, 0);
    #1;
    check("full_nwrites", 32'(wlog_addr.size()), 32'(DEPTH));
    if (wlog_addr.size() == DEPTH) begin
      int addr_bad;
      addr_bad = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (wlog_addr[k] != k) addr_bad++;
        if (wlog_data[k] !== {fb[4*k+3], fb[4*k+2], fb[4*k+1], fb[4*k]}) addr_bad++;
      end
      check("full_seq_errors", 32'(addr_bad), 32'd0);
      check("full_last_addr", 32'(wlog_addr[DEPTH-1]), 32'(DEPTH - 1));
      check("full_done_with_last", {31'd0, wlog_done[DEPTH-1]}, 32'd1);
    end

    // Randomised loads, with ignored mid-load starts and occasional aborts.
    for (int t = 0; t < 25; t++) begin
      int r, cnt;
      r = int'($urandom_range(0, 9));
      if (r == 0) cnt = 0;
      else if (r == 1) cnt = DEPTH + 1 + int'($urandom_range(0, 1000));
      else cnt = int'($urandom_range(1, 6));
      stream.delete();
      stream.push_back(8'(cnt)); stream.push_back(8'(cnt >> 8));
      if (cnt <= DEPTH) begin
        for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
      end
      if ($urandom_range(0, 4) == 0) begin
        int keep;
        keep = int'($urandom_range(1, stream.size()));
        while (stream.size() > keep) void'(stream.pop_back());
        do_start(); send(2, stream.size() > 3);
        do_reset();
      end else begin
        do_start(); send(2, stream.size() > 3);
      end
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
